// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: brings a divided clock into the clk100_mhz domain as data,
// strobes its edges, measures its rise-to-rise period and tracks ratio lock.
module clk_ratio_monitor #(
  parameter int EXPECTED_PERIOD = 4,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 8,
  parameter int TIMEOUT         = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk100_mhz,
  input  logic             reset,
  input  logic             slow_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost,
  output logic [15:0]      error_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]    EXP_V       = (CNT_W+1)'(EXPECTED_PERIOD);
  localparam logic [CNT_W:0]    TOL_V       = (CNT_W+1)'(TOLERANCE);
  localparam logic [CNT_W-1:0]  TIMEOUT_PRE = CNT_W'(TIMEOUT - 1);
  localparam logic [GOOD_W-1:0] LOCK_V      = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_e;

  logic              s1_q, s2_q, s3_q;
  logic              rise_evt, fall_evt;
  logic              rise_q, fall_q, pv_q, seen_rise_q;
  logic              locked_q, lost_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d, period_q;
  logic [CNT_W:0]    cnt_ext, diff;
  logic              in_tol, timeout_evt, err_inc;
  logic [15:0]       err_q;
  logic [GOOD_W-1:0] good_q, good_d;
  state_e            state_q, state_d;

  assign rise_evt = s2_q & ~s3_q;
  assign fall_evt = ~s2_q & s3_q;

  assign cnt_ext = {1'b0, cnt_q};
  assign diff    = (cnt_ext >= EXP_V) ? (cnt_ext - EXP_V) : (EXP_V - cnt_ext);
  assign in_tol  = (diff <= TOL_V);

  // A saturated counter never increments, so it can never re-enter TIMEOUT.
  assign timeout_evt = ~rise_evt & (cnt_q == TIMEOUT_PRE) & (cnt_q != CNT_MAX);

  always_comb begin
    if (rise_evt) begin
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_evt) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (rise_evt) begin
          if (in_tol) begin
            good_d = good_q + GOOD_W'(1);
            if (good_d == LOCK_V) begin
              state_d = LOCKED;
            end
          end else begin
            good_d  = '0;
            err_inc = 1'b1;
          end
        end else if (timeout_evt) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if ((rise_evt & ~in_tol) | timeout_evt) begin
          err_inc = 1'b1;
          state_d = LOST;
        end
      end
      LOST: begin
        err_inc = (rise_evt & ~in_tol) | timeout_evt;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100_mhz) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      pv_q        <= 1'b0;
      seen_rise_q <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      state_q     <= IDLE;
      good_q      <= '0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      err_q       <= 16'd0;
    end else begin
      s1_q        <= slow_clk;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      rise_q      <= rise_evt;
      fall_q      <= fall_evt;
      pv_q        <= rise_evt & seen_rise_q;
      seen_rise_q <= seen_rise_q | rise_evt;
      cnt_q       <= cnt_d;
      if (rise_evt) begin
        period_q <= cnt_q;
      end
      state_q     <= state_d;
      good_q      <= good_d;
      locked_q    <= (state_q == LOCKED);
      lost_q      <= (state_q == LOST);
      if (err_inc && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign error_count  = err_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Directed bench for clk_ratio_monitor: a TOLERANCE=0 instance (a) and a
// TOLERANCE=1 instance (b) share one slow_clk stimulus.
module tb_clk_ratio_monitor;

  logic        clk100_mhz = 1'b0;
  logic        reset      = 1'b1;
  logic        slow_clk   = 1'b0;

  logic        rise_pulse, fall_pulse, period_valid, locked, lost;
  logic [7:0]  period;
  logic [15:0] error_count;
  logic        b_rise, b_fall, b_pv, b_locked, b_lost;
  logic [7:0]  b_period;
  logic [15:0] b_err;

  int errors = 0;
  int checks = 0;
  int cyc, rp_cnt, fp_cnt, pv_cnt, rp_first, fp_first, last_rp_cyc;
  int pv8_cyc, lock_cyc, lost_cyc;
  int exp_period;

  clk_ratio_monitor #(.TOLERANCE(0)) dut_a (
    .clk100_mhz(clk100_mhz), .reset(reset), .slow_clk(slow_clk),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
    .period_valid(period_valid), .locked(locked), .lost(lost),
    .error_count(error_count)
  );

  clk_ratio_monitor #(.TOLERANCE(1)) dut_b (
    .clk100_mhz(clk100_mhz), .reset(reset), .slow_clk(slow_clk),
    .rise_pulse(b_rise), .fall_pulse(b_fall), .period(b_period),
    .period_valid(b_pv), .locked(b_locked), .lost(b_lost),
    .error_count(b_err)
  );

  always #5 clk100_mhz = ~clk100_mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; rp_cnt = 0; fp_cnt = 0; pv_cnt = 0;
    rp_first = -1; fp_first = -1; last_rp_cyc = -1;
    pv8_cyc = -1; lock_cyc = -1; lost_cyc = -1;
  endtask

  // Values seen just after edge n are the values held during cycle n+1.
  task automatic tick();
    @(posedge clk100_mhz);
    #1;
    cyc++;
    if (rise_pulse === 1'b1) begin
      rp_cnt++;
      last_rp_cyc = cyc;
      if (rp_first < 0) rp_first = cyc;
    end
    if (fall_pulse === 1'b1) begin
      fp_cnt++;
      if (fp_first < 0) fp_first = cyc;
    end
    if (period_valid === 1'b1) begin
      pv_cnt++;
      if (pv_cnt == 8) pv8_cyc = cyc;
      chk("period_on_valid", 32'(period), 32'(exp_period));
      chk("valid_with_rise", 32'(rise_pulse), 32'd1);
    end
    if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
    if (lost === 1'b1 && lost_cyc < 0) lost_cyc = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic run_slow(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      slow_clk = 1'b1;
      repeat (hi) tick();
      slow_clk = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    clear_stats();
    exp_period = 4;

    // Reset state
    tick();
    tick();
    chk("reset_strobes", 32'({rise_pulse, fall_pulse, period_valid, locked, lost}), 32'd0);
    chk("reset_period", 32'(period), 32'd0);
    chk("reset_errors", 32'(error_count), 32'd0);

    // Nominal ratio: period 4
    do_reset();
    run_slow(2, 2, 12);
    chk("nom_pv_count", 32'(pv_cnt), 32'd11);
    chk("nom_lock_latency", 32'(lock_cyc - pv8_cyc), 32'd1);
    chk("nom_locked", 32'(locked), 32'd1);
    chk("nom_errors", 32'(error_count), 32'd0);
    chk("nom_lost", 32'(lost), 32'd0);
    chk("nom_b_locked", 32'(b_locked), 32'd1);

    // Stuck low after lock: lost 16 cycles after the last rise_pulse
    for (int i = 0; i < 40 && lost_cyc < 0; i++) tick();
    chk("stuck_lost_cycle", 32'(lost_cyc), 32'(last_rp_cyc + 16));
    chk("stuck_locked", 32'(locked), 32'd0);
    chk("stuck_lost", 32'(lost), 32'd1);
    chk("stuck_errors", 32'(error_count), 32'd1);
    chk("stuck_rise_count", 32'(rp_cnt), 32'd12);
    chk("stuck_fall_count", 32'(fp_cnt), 32'd12);
    repeat (300) tick();
    chk("stuck_errors_hold", 32'(error_count), 32'd1);
    chk("stuck_lost_hold", 32'(lost), 32'd1);
    chk("stuck_pv_count", 32'(pv_cnt), 32'd11);

    // Off-ratio: period 5; a never locks, b (TOLERANCE=1) locks
    exp_period = 5;
    do_reset();
    run_slow(2, 3, 12);
    chk("off_pv_count", 32'(pv_cnt), 32'd11);
    chk("off_a_errors", 32'(error_count), 32'd11);
    chk("off_a_locked", 32'(lock_cyc), 32'hFFFF_FFFF);
    chk("off_a_lost", 32'(lost), 32'd0);
    chk("off_b_locked", 32'(b_locked), 32'd1);
    chk("off_b_errors", 32'(b_err), 32'd0);

    // Edge latency: rise sampled at edge 10, fall at edge 20
    exp_period = 4;
    do_reset();
    while (cyc < 9) tick();
    slow_clk = 1'b1;
    while (cyc < 19) tick();
    slow_clk = 1'b0;
    while (cyc < 26) tick();
    chk("lat_rise_cycle", 32'(rp_first), 32'd12);
    chk("lat_fall_cycle", 32'(fp_first), 32'd22);
    chk("lat_err_before_timeout", 32'(error_count), 32'd0);
    tick();
    chk("lat_acquire_timeout", 32'(error_count), 32'd1);
    while (cyc < 30) tick();
    chk("lat_rise_count", 32'(rp_cnt), 32'd1);
    chk("lat_fall_count", 32'(fp_cnt), 32'd1);
    chk("lat_pv_count", 32'(pv_cnt), 32'd0);
    chk("lat_locked", 32'(locked), 32'd0);

    // Reset while locked
    do_reset();
    run_slow(2, 2, 12);
    chk("rst_pre_locked", 32'(locked), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_strobes", 32'({rise_pulse, fall_pulse, period_valid, locked, lost}), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_errors", 32'(error_count), 32'd0);
    reset = 1'b0;
    clear_stats();
    run_slow(2, 2, 12);
    chk("rst_relock_latency", 32'(lock_cyc - pv8_cyc), 32'd1);
    chk("rst_relock_errors", 32'(error_count), 32'd0);

    // No clock from reset
    slow_clk = 1'b0;
    do_reset();
    repeat (100) tick();
    chk("noclk_strobes", 32'(rp_cnt + fp_cnt + pv_cnt), 32'd0);
    chk("noclk_errors", 32'(error_count), 32'd0);
    chk("noclk_state", 32'({locked, lost}), 32'd0);

    // slow_clk already high when reset is released
    slow_clk = 1'b1;
    do_reset();
    repeat (8) tick();
    chk("high_at_release_rise", 32'(rp_first), 32'd3);
    chk("high_at_release_count", 32'(rp_cnt), 32'd1);
    chk("high_at_release_pv", 32'(pv_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

- Sits in the 100 MHz domain and receives the divided 25 MHz pixel clock as a plain data signal.
- Synchronises the signal and produces single-cycle rise/fall strobes for fast-domain logic.
- Measures the slow clock's period in fast-clock cycles and reports whether the divided clock is locked to its expected ratio.
- Acts as the checking end of the clock-divider path, catching stuck or mis-ratioed derived clocks in hardware and in simulation.

## Interface
Parameters:
- EXPECTED_PERIOD, 4, nominal slow-clock period in clk100_mhz cycles
- TOLERANCE, 0, allowed absolute deviation from EXPECTED_PERIOD
- LOCK_COUNT, 8, consecutive in-tolerance periods required to lock
- TIMEOUT, 16, cycles without a rising edge that count as loss of clock
- CNT_W, 8, width of period counter and period output

Ports:
- clk100_mhz  input  1  system clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- slow_clk  input  1  divided clock, sampled as asynchronous data
- rise_pulse  output  1  one-cycle strobe per synchronised rising edge
- fall_pulse  output  1  one-cycle strobe per synchronised falling edge
- period  output  CNT_W  last measured rise-to-rise period
- period_valid  output  1  one-cycle strobe when period updates
- locked  output  1  high in LOCKED state
- lost  output  1  high in LOST state; sticky until reset
- error_count  output  16  saturating count of bad periods and timeouts

## Operation
**Synchroniser and edge detection**
- Three-flop chain s1 <= slow_clk, s2 <= s1, s3 <= s2.
- Edge events: rise_evt = s2 & ~s3; fall_evt = ~s2 & s3.
- rise_pulse and fall_pulse are registered copies of these events.

**Period counter cnt (CNT_W bits)**
- Reset value 0.
- On rise_evt: period <= cnt, cnt <= 1.
- Otherwise: cnt <= cnt + 1, saturating at 2^CNT_W-1.
- period_valid pulses on every rise_evt except the first one after reset, which has no prior edge.

**In-tolerance test**
- |cnt - EXPECTED_PERIOD| <= TOLERANCE, evaluated on the rise_evt cycle.
- Unsigned compare, with the subtraction done in CNT_W+1 bits.

**Timeout event**
- Fires in the single cycle where cnt increments into TIMEOUT with no rise_evt.
- Fires once per gap.
- If rise_evt and cnt == TIMEOUT coincide, the rise wins: this is a measured period, not a timeout.

**State machine**
- IDLE (reset state): first rise_evt -> ACQUIRE with good_cnt = 0. Timeouts are ignored in IDLE.
- ACQUIRE: in-tolerance period increments good_cnt. On reaching LOCK_COUNT -> LOCKED.
- ACQUIRE: out-of-tolerance period sets good_cnt = 0 and increments error_count. Stays in ACQUIRE.
- ACQUIRE: timeout increments error_count -> IDLE.
- LOCKED: out-of-tolerance period or timeout increments error_count -> LOST.
- LOST: terminal until reset. Measurement, strobes and error counting continue.

**Outputs**
- locked and lost are registered decodes of the state.
- error_count saturates at 16'hFFFF.

## Timing
- Reset values: s1, s2, s3 = 0; rise_pulse, fall_pulse, period_valid, locked, lost = 0; period = 0; error_count = 0; cnt = 0; state = IDLE.
- Latency: a slow_clk rise first sampled high at edge k gives rise_evt during cycle k+2 and rise_pulse high for exactly cycle k+3. fall_pulse has the same latency.
- period and period_valid update at the same edge as rise_pulse.
- locked/lost change one cycle after the period_valid (or timeout) that causes the transition.
- Reset mid-operation: every register returns to its reset value at the next edge.
- If slow_clk is high when reset is released, one rise_pulse appears 3 cycles later. It is consumed as IDLE's first rise.
- slow_clk is not required to have a 50% duty cycle. Only rising edges are timed.

## Test plan
1. **Nominal ratio.** slow_clk toggled every 2 fast cycles (period 4) from reset.
   - period = 4 on every period_valid.
   - locked = 1 one cycle after the 8th period_valid.
   - error_count = 0; lost = 0.
2. **Stuck clock after lock.** Hold slow_clk low after lock.
   - cnt reaching 16 triggers a timeout; lost = 1 and locked = 0 the following cycle.
   - error_count = 1, with no further increments while slow_clk stays stuck.
3. **Off-ratio clock.** Period 5 with TOLERANCE = 0.
   - Never locks; error_count increments by 1 per period_valid.
   - Rerun with TOLERANCE = 1: locks after 8 periods.
4. **Edge latency.** Single rise of slow_clk first sampled at edge 10.
   - rise_pulse high only in cycle 13.
   - fall first sampled at edge 20 gives fall_pulse high only in cycle 23.
5. **Reset while locked.** Assert reset for 1 cycle while locked.
   - All outputs = 0 next cycle; state = IDLE.
   - Relocks after 8 further good periods; error_count restarts at 0.
6. **No clock from reset.** slow_clk held low for 100 cycles.
   - State remains IDLE; error_count = 0; no strobes; period_valid never pulses.
